// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Default parameter constants and a counter-width helper used by
//               the pushbutton debounce bank and its per-channel sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  localparam int unsigned c_DEF_NUM_CH        = 4;
  localparam int unsigned c_DEF_STABLE_CYCLES = 270000;
  localparam int unsigned c_DEF_REPEAT_DELAY  = 13500000;
  localparam int unsigned c_DEF_REPEAT_PERIOD = 2700000;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One pushbutton channel: 2-flop synchronizer, stable-time
//               counter, debounced level, press/release pulses and optional
//               auto-repeat (enabled by macro DEBOUNCE_AUTOREPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = c_DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = c_DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = c_DEF_REPEAT_PERIOD
) (
  input  logic clk_27,
  input  logic reset_n,
  input  logic pb_raw,
  output logic pb_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);

  if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("debounce_channel: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic             r_press;
  logic             r_release;

  logic w_sampled;
  logic w_differs;
  logic w_accept;

  // Buttons are active-low on the pin; the synchronized level is inverted
  // so that 1 means pressed from here on.
  assign w_sampled = ~r_s2;
  assign w_differs = (w_sampled != r_state);
  // The counter only ever reaches STABLE_CYCLES-1 before it is cleared, so
  // it cannot wrap.
  assign w_accept  = w_differs && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  // Synchronize, time the stable interval and toggle the debounced level.
  always_ff @(posedge clk_27) begin
    if (!reset_n) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1 <= pb_raw;
      r_s2 <= r_s1;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_state <= ~r_state;
      end
      r_press   <= w_accept && !r_state;
      r_release <= w_accept && r_state;
    end
  end

  assign pb_state      = r_state;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_phase;
  logic             r_repeat;
  logic [RPT_W-1:0] w_rpt_target;

  // First interval is the initial delay, every later one the repeat period.
  assign w_rpt_target = r_rpt_phase ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);

  // Count held clocks; any accepted change (press or release) restarts the
  // timer and suppresses a pulse in that clock.
  always_ff @(posedge clk_27) begin
    if (!reset_n) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_repeat    <= 1'b0;
    end else if (!r_state || w_accept) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b0;
      r_repeat    <= 1'b0;
    end else if (r_rpt_cnt == w_rpt_target) begin
      r_rpt_cnt   <= '0;
      r_rpt_phase <= 1'b1;
      r_repeat    <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      r_repeat    <= 1'b0;
    end
  end

  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pushbutton_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_debounce_bank
// Description : Bank of NUM_CH independent pushbutton debouncers with
//               press/release pulses, a registered any-pressed flag and
//               optional auto-repeat (macro DEBOUNCE_AUTOREPEAT_EN).
//               A change is reflected on pb_state 2+STABLE_CYCLES clocks
//               after the clock in which the raw input changed.
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH        = c_DEF_NUM_CH,
  parameter int unsigned STABLE_CYCLES = c_DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = c_DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = c_DEF_REPEAT_PERIOD
) (
  input  logic              clk_27,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] pb_raw,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic              any_pressed
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_param_check
    $error("pushbutton_debounce_bank: NUM_CH must be in 1..32");
  end

  logic r_any;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_channel (
      .clk_27        (clk_27),
      .reset_n       (reset_n),
      .pb_raw        (pb_raw[gi]),
      .pb_state      (pb_state[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .repeat_pulse  (repeat_pulse[gi])
    );
  end

  // Registered OR of the debounced levels, one clock behind pb_state.
  always_ff @(posedge clk_27) begin
    if (!reset_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |pb_state;
    end
  end

  assign any_pressed = r_any;

endmodule
`default_nettype wire
